// File: rtl/correlator_array_if.sv
// Register-read bus between a host and the correlator array.
// A slave acknowledges one request per cycle; bursts keep ack_o high.
interface correlator_array_if #(
    parameter int NPAIR = 4
) ();
    localparam int AW = $clog2(2 * NPAIR + 1);

    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic          bst_i;
    logic [AW-1:0] adr_i;
    logic [31:0]   dat_i;
    logic          ack_o;
    logic [31:0]   dat_o;

    modport master (
        output cyc_i, stb_i, we_i, bst_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, bst_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/correlator_array.sv
// Double-banked 1-bit cos/sin correlator. One bank accumulates while the
// idle bank is read back over the register bus.
module correlator_array #(
    parameter int                   ANTENNAS = 24,
    parameter int                   NPAIR    = 4,
    parameter logic [NPAIR*16-1:0]  PAIRS    = {8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd3, 8'd0},
    parameter int                   ACCUM    = 32,
    parameter int                   DELAY    = 3
) (
    input  logic                clk_x,
    input  logic                rst,
    input  logic                en,
    input  logic                sw,
    input  logic [ANTENNAS-1:0] re,
    input  logic [ANTENNAS-1:0] im,
    correlator_array_if.slave   bus,
    output logic                rdy_o,
    output logic                overflow_cos,
    output logic                overflow_sin
);
    localparam logic [ACCUM-1:0] ACC_ZERO = {ACCUM{1'b0}};
    localparam logic [ACCUM-1:0] ACC_ONE  = {{(ACCUM-1){1'b0}}, 1'b1};
    localparam logic [ACCUM-1:0] ACC_MAX  = {ACCUM{1'b1}};
    localparam int               LAST_ADR = 2 * NPAIR;

    logic             act_r;
    logic             rdy_r;
    logic             ack_r;
    logic [31:0]      dat_r;
    logic             ovf_cos_r;
    logic             ovf_sin_r;
    logic [ACCUM-1:0] cos_r [0:1][0:NPAIR-1];
    logic [ACCUM-1:0] sin_r [0:1][0:NPAIR-1];
    logic [31:0]      cnt_r [0:1];

    logic [NPAIR-1:0] cos_hit_s;
    logic [NPAIR-1:0] sin_hit_s;
    logic             wbank_s;
    logic             rd_bank_s;
    logic [ACCUM-1:0] cos_wr_s [0:NPAIR-1];
    logic [ACCUM-1:0] sin_wr_s [0:NPAIR-1];
    logic [31:0]      cnt_wr_s;
    logic             cos_sat_s;
    logic             sin_sat_s;
    int               adr_s;
    logic             req_s;
    logic             rd_last_s;
    logic [31:0]      rd_data_s;
    logic             unused_dat_s;

    function automatic logic [31:0] zext(input logic [ACCUM-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[ACCUM-1:0] = v;
        return r;
    endfunction

    // Next accumulator value: a switch restarts the bank from zero first.
    function automatic logic [ACCUM-1:0] acc_next(input logic [ACCUM-1:0] v,
                                                  input logic clr, input logic hit);
        logic [ACCUM-1:0] base;
        base = clr ? ACC_ZERO : v;
        if (hit && (base != ACC_MAX)) begin
            return base + ACC_ONE;
        end else begin
            return base;
        end
    endfunction

    function automatic logic acc_sat(input logic [ACCUM-1:0] v,
                                     input logic clr, input logic hit);
        return hit && !clr && (v == ACC_MAX);
    endfunction

    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
        localparam int IA = int'(PAIRS[p*16+8 +: 8]);
        localparam int IB = int'(PAIRS[p*16 +: 8]);
        assign cos_hit_s[p] = ~(re[IA] ^ re[IB]);
        assign sin_hit_s[p] = ~(re[IA] ^ im[IB]);
    end

    assign wbank_s   = act_r ^ sw;
    assign rd_bank_s = ~act_r;

    // Compute the written bank's next contents and saturation events.
    always_comb begin
        cnt_wr_s  = (sw ? 32'd0 : cnt_r[wbank_s]) + (en ? 32'd1 : 32'd0);
        cos_sat_s = 1'b0;
        sin_sat_s = 1'b0;
        for (int p = 0; p < NPAIR; p++) begin
            cos_wr_s[p] = acc_next(cos_r[wbank_s][p], sw, en & cos_hit_s[p]);
            sin_wr_s[p] = acc_next(sin_r[wbank_s][p], sw, en & sin_hit_s[p]);
            cos_sat_s   = cos_sat_s | acc_sat(cos_r[wbank_s][p], sw, en & cos_hit_s[p]);
            sin_sat_s   = sin_sat_s | acc_sat(sin_r[wbank_s][p], sw, en & sin_hit_s[p]);
        end
    end

    // Bank storage, bank select and sticky overflow flags.
    always_ff @(posedge clk_x) begin
        if (rst) begin
            act_r     <= 1'b0;
            ovf_cos_r <= 1'b0;
            ovf_sin_r <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                cnt_r[b] <= 32'd0;
                for (int p = 0; p < NPAIR; p++) begin
                    cos_r[b][p] <= ACC_ZERO;
                    sin_r[b][p] <= ACC_ZERO;
                end
            end
        end else begin
            act_r     <= wbank_s;
            ovf_cos_r <= (ovf_cos_r & ~sw) | cos_sat_s;
            ovf_sin_r <= (ovf_sin_r & ~sw) | sin_sat_s;
            if (sw || en) begin
                cnt_r[wbank_s] <= cnt_wr_s;
                for (int p = 0; p < NPAIR; p++) begin
                    cos_r[wbank_s][p] <= cos_wr_s[p];
                    sin_r[wbank_s][p] <= sin_wr_s[p];
                end
            end
        end
    end

    assign adr_s = int'(bus.adr_i);

    // Register map of the idle bank; unmatched addresses read as zero.
    always_comb begin
        rd_data_s = (adr_s == LAST_ADR) ? cnt_r[rd_bank_s] : 32'd0;
        for (int p = 0; p < NPAIR; p++) begin
            rd_data_s = rd_data_s
                      | ({32{adr_s == 2 * p}}     & zext(cos_r[rd_bank_s][p]))
                      | ({32{adr_s == 2 * p + 1}} & zext(sin_r[rd_bank_s][p]));
        end
    end

    // A request is taken when idle, or every cycle while bursting.
    assign req_s     = bus.cyc_i & bus.stb_i & (bus.bst_i | ~ack_r);
    assign rd_last_s = req_s & ~bus.we_i & (adr_s == LAST_ADR);

    // Bus response pipeline and block-ready flag.
    always_ff @(posedge clk_x) begin
        if (rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
            rdy_r <= 1'b0;
        end else begin
            ack_r <= req_s;
            rdy_r <= sw | (rdy_r & ~rd_last_s);
            if (req_s) begin
                dat_r <= rd_data_s;
            end
        end
    end

    assign bus.ack_o    = ack_r;
    assign bus.dat_o    = dat_r;
    assign rdy_o        = rdy_r;
    assign overflow_cos = ovf_cos_r;
    assign overflow_sin = ovf_sin_r;

    // Write data and the simulation delay carry no function.
    assign unused_dat_s = (^bus.dat_i) ^ (DELAY < 0);
endmodule

// File: tb/tb_correlator_array.sv
// Randomised scoreboard bench for correlator_array with a behavioural
// model of both banks, ready flag, overflow flags and bus acknowledge.
module tb_correlator_array;
    localparam int ANTENNAS = 24;
    localparam int NPAIR    = 4;
    localparam int ACCUM    = 8;
    localparam logic [NPAIR*16-1:0] PAIRS = {8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd3, 8'd0};
    localparam int LAST = 2 * NPAIR;
    localparam int AW   = $clog2(2 * NPAIR + 1);
    localparam int AMAX = (1 << ACCUM) - 1;

    logic clk_x = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    logic sw    = 1'b0;
    logic [ANTENNAS-1:0] re = {ANTENNAS{1'b0}};
    logic [ANTENNAS-1:0] im = {ANTENNAS{1'b0}};
    logic rdy_o, overflow_cos, overflow_sin;

    correlator_array_if #(.NPAIR(NPAIR)) bus ();

    correlator_array #(
        .ANTENNAS(ANTENNAS), .NPAIR(NPAIR), .PAIRS(PAIRS), .ACCUM(ACCUM), .DELAY(3)
    ) dut (
        .clk_x(clk_x), .rst(rst), .en(en), .sw(sw), .re(re), .im(im),
        .bus(bus), .rdy_o(rdy_o), .overflow_cos(overflow_cos), .overflow_sin(overflow_sin)
    );

    always #5 clk_x = ~clk_x;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    // Behavioural model state
    int          mcos [2][NPAIR];
    int          msin [2][NPAIR];
    logic [31:0] mcnt [2];
    int          mact = 0;
    bit          mrdy = 1'b0;
    bit          mack = 1'b0;
    bit          movc = 1'b0;
    bit          movs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int adr);
        int ib;
        ib = 1 - mact;
        if (adr < LAST) return (adr % 2 == 1) ? msin[ib][adr/2] : mcos[ib][adr/2];
        else if (adr == LAST) return mcnt[ib];
        else return 32'd0;
    endfunction

    task automatic model_clear_bank(input int b);
        for (int p = 0; p < NPAIR; p++) begin
            mcos[b][p] = 0;
            msin[b][p] = 0;
        end
        mcnt[b] = 32'd0;
    endtask

    // What the design must do at this rising edge, given the current inputs.
    task automatic model_edge();
        logic [NPAIR*16-1:0] pv;
        int a, b, adr;
        bit req, clr;
        pv = PAIRS;
        if (rst) begin
            model_clear_bank(0);
            model_clear_bank(1);
            mact = 0; mrdy = 0; mack = 0; movc = 0; movs = 0;
            return;
        end
        adr = int'(bus.adr_i);
        req = bus.cyc_i && bus.stb_i && (bus.bst_i || !mack);
        clr = 1'b0;
        if (req) begin
            exp_q.push_back(model_read(adr));
            clr = !bus.we_i && (adr == LAST);
        end
        mack = req;
        if (sw) begin
            mact = 1 - mact;
            model_clear_bank(mact);
            movc = 0;
            movs = 0;
        end
        if (en) begin
            for (int p = 0; p < NPAIR; p++) begin
                a = int'(pv[p*16+8 +: 8]);
                b = int'(pv[p*16 +: 8]);
                if (re[a] == re[b]) begin
                    if (mcos[mact][p] == AMAX) movc = 1; else mcos[mact][p]++;
                end
                if (re[a] == im[b]) begin
                    if (msin[mact][p] == AMAX) movs = 1; else msin[mact][p]++;
                end
            end
            mcnt[mact] = mcnt[mact] + 32'd1;
        end
        mrdy = sw ? 1'b1 : (clr ? 1'b0 : mrdy);
    endtask

    task automatic tick();
        @(posedge clk_x);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input int adr, input bit we);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = AW'(adr); bus.dat_i = $urandom;
        tick();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        tick();
    endtask

    task automatic burst(input int lo, input int hi);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.bst_i = 1'b1;
        for (int a = lo; a <= hi; a++) begin
            bus.adr_i = AW'(a);
            tick();
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.bst_i = 1'b0;
        tick();
    endtask

    // Monitor: compare status every cycle and pop read data on each ack.
    initial begin
        forever begin
            @(negedge clk_x);
            chk("ack", {31'd0, bus.ack_o}, {31'd0, mack});
            chk("rdy", {31'd0, rdy_o}, {31'd0, mrdy});
            chk("ovf_cos", {31'd0, overflow_cos}, {31'd0, movc});
            chk("ovf_sin", {31'd0, overflow_sin}, {31'd0, movs});
            if (bus.ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack at %0t: got ack with data %0h expected no ack", $time, bus.dat_o);
                end else begin
                    chk("rd_data", bus.dat_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.bst_i = 1'b0;
        bus.adr_i = {AW{1'b0}}; bus.dat_i = 32'd0;
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("dat_after_rst", bus.dat_o, 32'd0);
        burst(0, LAST + 1);

        // Twelve all-ones samples, then switch and read the whole bank
        re = {ANTENNAS{1'b1}}; im = {ANTENNAS{1'b1}}; en = 1'b1;
        idle(12);
        en = 1'b0; sw = 1'b1;
        tick();
        sw = 1'b0;
        idle(1);
        burst(0, LAST + 1);

        // Random samples, then switch; a write to the last address must not clear rdy
        en = 1'b1;
        for (int i = 0; i < 96; i++) begin
            re = ANTENNAS'($urandom); im = ANTENNAS'($urandom);
            tick();
        end
        en = 1'b0; sw = 1'b1;
        tick();
        sw = 1'b0;
        rd(LAST, 1'b1);
        for (int a = 0; a <= LAST + 1; a++) rd(a, 1'b0);

        // Burst with random accumulation and a switch in the middle
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.bst_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.adr_i = AW'($urandom_range(0, LAST + 1));
            en = 1'($urandom_range(0, 1));
            re = ANTENNAS'($urandom); im = ANTENNAS'($urandom);
            sw = (i == 10);
            tick();
        end
        sw = 1'b0; en = 1'b0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.bst_i = 1'b0;
        tick();
        burst(0, LAST);

        // Switch with a sample on the same edge
        en = 1'b1; re = ANTENNAS'($urandom); im = ANTENNAS'($urandom); sw = 1'b1;
        tick();
        en = 1'b0; sw = 1'b0;
        rd(LAST, 1'b0);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        burst(0, LAST);

        // Saturation at 2^ACCUM-1, flag clears on the next switch
        re = {ANTENNAS{1'b0}}; im = {ANTENNAS{1'b0}}; en = 1'b1;
        idle(300);
        en = 1'b0; sw = 1'b1;
        tick();
        sw = 1'b0;
        burst(0, LAST + 1);

        // Switch and last-address read on the same edge keep rdy set
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = AW'(LAST); sw = 1'b1;
        tick();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; sw = 1'b0;
        idle(2);

        // Reset in the middle of a burst, with en and sw ignored
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.bst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.adr_i = AW'(i);
            tick();
        end
        rst = 1'b1; en = 1'b1; sw = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; sw = 1'b0;
        bus.adr_i = AW'(0);    tick();
        bus.adr_i = AW'(LAST); tick();
        bus.adr_i = AW'(1);    tick();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.bst_i = 1'b0;
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
